// File: rtl/sal_rd_resp_buf_if.sv
// sal_rd_resp_buf_if: groups the scheduler command port, the DFI read-data port,
// the AXI R channel and the status outputs of the read-response buffer.
// Ports: cmd_* (tag post with ready), dfi_rddata* (no backpressure),
//        r* (AXI R, valid/ready), outstanding / err_unexpected (status).
interface sal_rd_resp_buf_if #(
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int TAG_DEPTH = 8
) ();
    // Scheduler command port
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [ID_W-1:0]              cmd_id;
    logic                         cmd_last;
    // DFI read data
    logic                         dfi_rddata_valid;
    logic [DATA_W-1:0]            dfi_rddata;
    // AXI R channel
    logic                         rvalid;
    logic                         rready;
    logic [ID_W-1:0]              rid;
    logic [DATA_W-1:0]            rdata;
    logic [1:0]                   rresp;
    logic                         rlast;
    // Status
    logic [$clog2(TAG_DEPTH):0]   outstanding;
    logic                         err_unexpected;

    // The buffer itself
    modport slave (
        input  cmd_valid, cmd_id, cmd_last,
        input  dfi_rddata_valid, dfi_rddata,
        input  rready,
        output cmd_ready,
        output rvalid, rid, rdata, rresp, rlast,
        output outstanding, err_unexpected
    );

    // Scheduler + DFI PHY + AXI master side
    modport master (
        output cmd_valid, cmd_id, cmd_last,
        output dfi_rddata_valid, dfi_rddata,
        output rready,
        input  cmd_ready,
        input  rvalid, rid, rdata, rresp, rlast,
        input  outstanding, err_unexpected
    );
endinterface

// File: rtl/sal_rd_resp_buf.sv
// sal_rd_resp_buf: DDR2 read-response buffer, DFI read beats -> AXI R beats,
// paired in order with the tags the scheduler posts per RD command.
// Latency: a DFI beat captured at edge N is presented on R after edge N+1.
// Backpressure: rready stalls R (outputs held); cmd_ready is withheld until a
// tag slot and BEATS_PER_CMD data credits are free, so DFI never overflows.
// Ports: clk, rst_n (async, active-high), bus (sal_rd_resp_buf_if.slave).

// Generic synchronous FIFO: extra pointer bit distinguishes full from empty.
// Latency: written entry visible at rdat_o after the write edge.
// Backpressure: none internally; callers must respect full_o / empty_o.
module sal_rd_resp_buf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdat_i,
    input  logic         pop_i,
    output logic [W-1:0] rdat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
    end

    assign rdat_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module sal_rd_resp_buf #(
    parameter int DATA_W        = 128,
    parameter int ID_W          = 4,
    parameter int BEATS_PER_CMD = 2,
    parameter int DATA_DEPTH    = 16,
    parameter int TAG_DEPTH     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sal_rd_resp_buf_if.slave bus
);
    localparam int CNT_W = (BEATS_PER_CMD > 1) ? $clog2(BEATS_PER_CMD) : 1;
    localparam int OUT_W = $clog2(TAG_DEPTH) + 1;
    localparam int CRD_W = $clog2(DATA_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_CMD - 1);
    localparam logic [CRD_W-1:0] CMD_COST  = CRD_W'(BEATS_PER_CMD);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } tag_t;

    // FIFO hookups
    tag_t              tag_wdat, tag_head;
    logic              tag_full, tag_empty;
    logic [DATA_W-1:0] dat_head;
    logic              dat_full, dat_empty;

    // State
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [OUT_W-1:0]  pend_q, pend_d;        // tags still awaiting DFI beats
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;  // beat index within capturing tag
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;  // beat index within head tag
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Events
    logic cmd_ready_c;
    logic cmd_push;
    logic beat_ok;
    logic beat_drop;
    logic cap_done;
    logic r_hs;
    logic tag_pop;
    logic dat_load;
    logic head_ok;

    assign cmd_ready_c = !tag_full && !dat_full && (credit_q >= CMD_COST);
    assign cmd_push    = bus.cmd_valid && cmd_ready_c;

    // A beat is only legal if some tag is still waiting for data.
    assign beat_ok   = bus.dfi_rddata_valid && (pend_q != '0);
    assign beat_drop = bus.dfi_rddata_valid && (pend_q == '0);
    assign cap_done  = beat_ok && (cap_cnt_q == LAST_BEAT);

    assign r_hs    = rvalid_q && bus.rready;
    assign tag_pop = r_hs && (out_cnt_q == LAST_BEAT);

    // Output register refills whenever it is empty or being drained.
    assign dat_load = !dat_empty && (!rvalid_q || bus.rready);

    assign tag_wdat = '{id: bus.cmd_id, last: bus.cmd_last};

    sal_rd_resp_buf_fifo #(
        .W     ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_push),
        .wdat_i  (tag_wdat),
        .pop_i   (tag_pop),
        .rdat_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    sal_rd_resp_buf_fifo #(
        .W     (DATA_W),
        .DEPTH (DATA_DEPTH)
    ) u_dat_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (beat_ok),
        .wdat_i  (bus.dfi_rddata),
        .pop_i   (dat_load),
        .rdat_o  (dat_head),
        .full_o  (dat_full),
        .empty_o (dat_empty)
    );

    always_comb begin
        credit_d      = credit_q;
        outstanding_d = outstanding_q;
        pend_d        = pend_q;
        cap_cnt_d     = cap_cnt_q;
        out_cnt_d     = out_cnt_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        err_d         = err_q | beat_drop;

        // Credit covers FIFO plus output register; returned one per R beat.
        if (cmd_push) credit_d = credit_d - CMD_COST;
        if (r_hs)     credit_d = credit_d + CRD_W'(1);

        if (cmd_push) outstanding_d = outstanding_d + OUT_W'(1);
        if (tag_pop)  outstanding_d = outstanding_d - OUT_W'(1);

        if (cmd_push) pend_d = pend_d + OUT_W'(1);
        if (cap_done) pend_d = pend_d - OUT_W'(1);

        if (beat_ok)
            cap_cnt_d = cap_done ? '0 : cap_cnt_q + CNT_W'(1);

        if (r_hs)
            out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + CNT_W'(1);

        if (dat_load) begin
            rvalid_d = 1'b1;
            rdata_d  = dat_head;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            credit_q      <= CRD_W'(DATA_DEPTH);
            outstanding_q <= '0;
            pend_q        <= '0;
            cap_cnt_q     <= '0;
            out_cnt_q     <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            credit_q      <= credit_d;
            outstanding_q <= outstanding_d;
            pend_q        <= pend_d;
            cap_cnt_q     <= cap_cnt_d;
            out_cnt_q     <= out_cnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    // Every buffered beat belongs to the head tag, so rid/rlast come straight
    // from it; they are forced to 0 when idle so stale tag storage never shows.
    assign head_ok = rvalid_q && !tag_empty;

    assign bus.cmd_ready      = cmd_ready_c;
    assign bus.rvalid         = rvalid_q;
    assign bus.rdata          = rdata_q;
    assign bus.rid            = head_ok ? tag_head.id : '0;
    assign bus.rlast          = head_ok && tag_head.last && (out_cnt_q == LAST_BEAT);
    assign bus.rresp          = 2'b00;
    assign bus.outstanding    = outstanding_q;
    assign bus.err_unexpected = err_q;
endmodule

// File: doc/sal_rd_resp_buf.md
Name: sal_rd_resp_buf

Overview:
- Read-response buffer inside the DDR2 controller, between the DFI read interface and the AXI R channel.
- The scheduler posts one tag per issued DRAM RD command. The buffer captures the unthrottled dfi_rddata beats, pairs them in order with their tags, and drives AXI R beats with RID/RLAST under rready backpressure.
- It issues read credits so the scheduler never launches a read whose data cannot be stored.

Parameters:
- DATA_W, 128, DFI rddata width = AXI RDATA width (2 x 64-bit DQ).
- ID_W, 4, AXI ID width.
- BEATS_PER_CMD, 2, DFI data beats returned per RD command (BL4, 1:1 DFI).
- DATA_DEPTH, 16, data FIFO entries; power of 2, >= BEATS_PER_CMD.
- TAG_DEPTH, 8, outstanding-command tag FIFO entries; power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  scheduler issues a RD command this cycle
- cmd_ready  out  1  tag slot and data credit available
- cmd_id  in  ID_W  AXI ID of the command
- cmd_last  in  1  command is the final one of its AXI burst
- dfi_rddata_valid  in  1  DFI read beat valid (no backpressure)
- dfi_rddata  in  DATA_W  DFI read data
- rvalid  out  1  AXI R valid
- rready  in  1  AXI R ready
- rid  out  ID_W  AXI RID
- rdata  out  DATA_W  AXI RDATA
- rresp  out  2  always 2'b00 (OKAY)
- rlast  out  1  AXI RLAST
- outstanding  out  $clog2(TAG_DEPTH)+1  tags pushed and not fully drained
- err_unexpected  out  1  sticky: DFI beat arrived with no outstanding tag

Behaviour:
- Reset (rst_n high, async): FIFOs empty, credit = DATA_DEPTH, beat counters 0. Outputs: rvalid=0, rlast=0, rid=0, rdata=0, outstanding=0, err_unexpected=0. cmd_ready is combinational and reads 1 after reset.
- cmd_ready = (tag FIFO not full) && (credit >= BEATS_PER_CMD).
- Command push: when cmd_valid && cmd_ready, push {cmd_id, cmd_last} and subtract BEATS_PER_CMD from credit. cmd_valid while !cmd_ready is ignored; the scheduler must hold it.
- Credit returns +1 per R handshake (rvalid && rready). If a push and a handshake fall in the same cycle, credit = credit - BEATS_PER_CMD + 1. Credit never exceeds DATA_DEPTH and never goes below 0.
- DFI capture: each dfi_rddata_valid cycle writes one data FIFO entry at the clock edge. Overflow cannot occur while credits are honoured.
- DFI beat with no outstanding tag (tags pushed minus tags fully captured = 0): beat dropped, err_unexpected set (sticky until reset), no FIFO write.
- Output: registered data FIFO head. A beat captured at edge N gives rvalid=1 after edge N+1, so first RDATA appears one cycle after the DFI beat. Back-to-back DFI beats stream at one beat per cycle when rready=1.
- rid = head tag id. rlast = head tag last && (out_beat_cnt == BEATS_PER_CMD-1).
- out_beat_cnt increments per handshake and wraps to 0 at BEATS_PER_CMD-1. The tag pops on that wrapping handshake.
- rvalid, rdata, rid, rlast stay stable while rvalid && !rready (AXI hold rule).
- In-order only: no reordering across IDs.
- outstanding: +1 on command push, -1 on tag pop; a push and pop in the same cycle leave it unchanged.
- Data FIFO full and tag FIFO full: cmd_ready=0. Empty: rvalid=0. Pointers wrap modulo depth; full/empty use an extra pointer bit.
- Reset mid-operation: all in-flight data discarded, state returns to the reset values above.

Test Plan:
- Single command (id=4'h3, last=1), DFI beats 0xA..A then 0xB..B on consecutive cycles, rready=1 -> two R beats one cycle after each DFI beat, rid=3, rlast on the second only, credit back to 16.
- Two commands (id=1, last=0) then (id=1, last=1) -> four beats in order, rlast only on the 4th, outstanding goes 2 -> 0.
- Push 8 commands with rready=0 -> credit reaches 0 after the 8th push and cmd_ready=0. A 9th cmd_valid is ignored. One R handshake still leaves cmd_ready=0; the second handshake raises it.
- rready toggling 1,0,0,1 during a 4-beat stream -> rdata/rid/rlast held while stalled, no beat lost or duplicated.
- dfi_rddata_valid with outstanding=0 -> err_unexpected=1 next cycle and stays 1, rvalid remains 0.
- Assert reset while 3 beats are buffered -> rvalid=0, outstanding=0, cmd_ready=1, err_unexpected=0 immediately (async).
